pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Sequencing controller for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Each cycle it decides which stages advance, which capture a bubble, and when the pipe freezes for an outstanding data-memory access or a HALT. It sits beside the datapath in the CPU top level and drives every pipeline register's enable and flush pin. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- CNT_W, 16, width of the stall-cycle counter.
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch for the current PC completes this cycle.
- dhit  in  1  data access issued from MEM completes this cycle.
- mem_dREN, mem_dWEN  in  1 each  load/store request held in EX/MEM.
- mem_halt  in  1  EX/MEM holds a HALT.
- ex_redirect  in  1  branch taken or jump resolved in EX; PC is being redirected.
- idex_dREN  in  1  ID/EX holds a load.
- idex_wsel  in  5  destination register of the ID/EX instruction.
- ifid_rs, ifid_rt  in  5 each  source registers of the IF/ID instruction.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush  out  1 each  load bubble instead of data; only meaningful while the matching enable is 1.
- dmem_ren, dmem_wen  out  1 each  gated data request to the memory arbiter.
- halt  out  1  processor halted.
- stall_cnt  out  CNT_W  saturating count of non-advancing cycles.

## Operation
- States: RUN, DWAIT, HALTED. Reset state is RUN.
- memreq = mem_dREN | mem_dWEN. dmem_ren = mem_dREN and dmem_wen = mem_dWEN in RUN and DWAIT. Both are 0 in HALTED.
- advance:
  - RUN: advance = ihit & (!memreq | dhit).
  - DWAIT: advance = dhit. The arbiter gives data priority, so ihit is ignored here.
  - HALTED: advance = 0.
- Base enables: all five enables equal advance. Both flushes are 0.
- Load-use hazard: lu = idex_dREN & (idex_wsel != 0) & (idex_wsel == ifid_rs | idex_wsel == ifid_rt).
  - When lu & advance: pc_en = 0, ifid_en = 0, idex_flush = 1. idex_en, exmem_en and memwb_en stay 1.
- Redirect: when ex_redirect & advance, ifid_flush = 1 and idex_flush = 1, with all enables 1.
  - Redirect has priority over load-use: lu is ignored, so pc_en = ifid_en = 1.
- Transitions:
  - RUN to DWAIT: memreq & !dhit & ihit.
  - RUN to HALTED: mem_halt & advance.
  - DWAIT to RUN: dhit & !mem_halt. The pipe advances that same cycle under the RUN hazard rules.
  - DWAIT to HALTED: dhit & mem_halt.
  - HALTED: terminal until reset.
- halt = 1 in HALTED, else 0.
- stall_cnt:
  - Increments by 1 on each cycle in RUN or DWAIT where advance = 0 or an lu bubble is inserted.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Frozen in HALTED.

## Timing
- Enables, flushes and dmem_* are combinational from the registered state and the current inputs. Zero-cycle latency: the pipeline registers act on the same rising edge.
- State, halt and stall_cnt are registered and update on the rising CLK edge.
- Reset (nRST = 0, at any time, including mid-DWAIT):
  - State goes to RUN, stall_cnt to 0, halt to 0.
  - All enables, flushes and dmem_* are forced to 0 while nRST = 0.
- Load-use costs exactly one bubble cycle. The next cycle, ID/EX no longer holds the load, so lu drops.
- Miss with dhit arriving N cycles after entry to DWAIT: the pipe is frozen for N cycles. stall_cnt rises by N (plus 1 for the entry cycle in RUN).
- HALT: the cycle HALT advances out of EX/MEM, memwb_en = 1 and HALT is captured in MEM/WB. From the next cycle, everything is frozen and halt = 1.
- Simultaneous ex_redirect, lu and memreq & !dhit: freeze wins, and no flush is emitted. The hazards are re-evaluated on the cycle dhit arrives.

## Test plan
- Reset mid-DWAIT: hold mem_dREN = 1 with dhit = 0 for 3 cycles, then pulse nRST low.
  - Required: state RUN, stall_cnt = 0, all enables 0 during reset.
  - Required: all enables 1 on the first ihit = 1 cycle afterwards.
- Load-use: idex_dREN = 1, idex_wsel = 8, ifid_rs = 8, ihit = 1, no memreq.
  - Required: pc_en = ifid_en = 0, idex_en = idex_flush = 1, exmem_en = memwb_en = 1, stall_cnt += 1.
  - Repeat with idex_wsel = 0: required no bubble.
- Data miss: mem_dWEN = 1, dhit low for 4 cycles, then high.
  - Required: all enables 0 for 4 cycles, dmem_wen = 1 throughout.
  - Required: enables 1 on the dhit cycle, then RUN, stall_cnt = 4.
- Redirect plus load-use in the same cycle: ex_redirect = 1, lu condition true, ihit = 1.
  - Required: all enables 1, ifid_flush = idex_flush = 1, stall_cnt unchanged.
- HALT: mem_halt = 1, ihit = 1, no memreq.
  - Required: memwb_en = 1 that cycle.
  - Required next cycle: halt = 1 and all enables 0, held for 20 cycles with ihit toggling.
- Saturation: CNT_W = 4, ihit = 0 for 20 cycles.
  - Required: stall_cnt stops at 15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: per-cycle enables/flushes for PC and the four stage registers,
// data-miss freeze, load-use bubble, redirect flush, HALT, and a saturating stall-cycle counter.
module pipeline_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             mem_halt,
   input  logic             ex_redirect,
   input  logic             idex_dREN,
   input  logic [4:0]       idex_wsel,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             dmem_ren,
   output logic             dmem_wen,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_memreq, w_lu, w_adv, w_stall_inc;

   assign w_memreq = mem_dREN | mem_dWEN;
   assign w_lu     = idex_dREN & (idex_wsel != 5'd0) &
                     ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= RUN;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   always_comb begin
      w_adv       = 1'b0;
      w_next      = r_state;
      w_stall_inc = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      dmem_ren    = 1'b0;
      dmem_wen    = 1'b0;

      case (r_state)
         RUN: begin
            w_adv = ihit & (~w_memreq | dhit);
            if (w_memreq && !dhit && ihit) w_next = DWAIT;
            else if (mem_halt && w_adv)    w_next = HALTED;
         end
         DWAIT: begin
            // Data side owns the arbiter here, so a pending ifetch cannot hold us.
            w_adv = dhit;
            if (dhit) w_next = mem_halt ? HALTED : RUN;
         end
         default: w_adv = 1'b0;
      endcase

      if (r_state != HALTED)
         w_stall_inc = ~w_adv | (w_lu & ~ex_redirect);

      // Outputs are held low throughout reset regardless of the inputs.
      if (nRST) begin
         pc_en    = w_adv;
         ifid_en  = w_adv;
         idex_en  = w_adv;
         exmem_en = w_adv;
         memwb_en = w_adv;
         if (r_state != HALTED) begin
            dmem_ren = mem_dREN;
            dmem_wen = mem_dWEN;
         end
         if (w_adv && ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (w_adv && w_lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end
   end

   assign halt      = (r_state == HALTED);
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stimulus pushes hand-computed expectations, a negedge monitor
// pops and compares one entry per cycle.
module tb_pipeline_ctrl;

   localparam int CNT_W = 4;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_redirect, idex_dREN;
   logic [4:0]       idex_wsel, ifid_rs, ifid_rt;
   logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic             ifid_flush, idex_flush, dmem_ren, dmem_wen, halt;
   logic [CNT_W-1:0] stall_cnt;

   typedef struct {
      logic [4:0]       en;
      logic [1:0]       fl;
      logic [1:0]       dm;
      logic             hlt;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   pipeline_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
      .ex_redirect(ex_redirect), .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .halt(halt), .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic cmp(input string nm, input string field, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, req);
   endtask

   // Monitor: the controller presents a full output set every cycle.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         cmp(nm, "en",   {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e.en);
         cmp(nm, "fl",   {ifid_flush, idex_flush}, e.fl);
         cmp(nm, "dm",   {dmem_ren, dmem_wen}, e.dm);
         cmp(nm, "halt", halt, e.hlt);
         cmp(nm, "cnt",  stall_cnt, e.cnt);
      end
   end

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_halt = 1'b0;
      ex_redirect = 1'b0; idex_dREN = 1'b0; idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
   endtask

   // Push the expectation for the inputs currently driven, then move to the next cycle.
   task automatic step(input string nm, input logic [4:0] en, input logic [1:0] fl,
                       input logic [1:0] dm, input logic hlt, input int cnt);
      exp_t e;
      e.en = en; e.fl = fl; e.dm = dm; e.hlt = hlt; e.cnt = cnt[CNT_W-1:0];
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      idle();
      nRST = 1'b0;
      step("reset", 5'b00000, 2'b00, 2'b00, 1'b0, 0);
      nRST = 1'b1;
   endtask

   initial begin
      idle();
      nRST = 1'b0;
      @(posedge CLK);
      #1;
      step("reset0", 5'b00000, 2'b00, 2'b00, 1'b0, 0);
      nRST = 1'b1;

      // Reset in the middle of a data-miss freeze.
      mem_dREN = 1'b1;
      step("miss_run",  5'b00000, 2'b00, 2'b10, 1'b0, 0);
      step("miss_dw1",  5'b00000, 2'b00, 2'b10, 1'b0, 1);
      step("miss_dw2",  5'b00000, 2'b00, 2'b10, 1'b0, 2);
      nRST = 1'b0;
      step("rst_mid",   5'b00000, 2'b00, 2'b00, 1'b0, 0);
      nRST = 1'b1;
      idle();
      step("after_rst", 5'b11111, 2'b00, 2'b00, 1'b0, 0);

      // Load-use bubble, then the same with a zero destination.
      idex_dREN = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8;
      step("lu",        5'b00111, 2'b01, 2'b00, 1'b0, 0);
      idle();
      step("lu_after",  5'b11111, 2'b00, 2'b00, 1'b0, 1);
      idex_dREN = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
      step("lu_r0",     5'b11111, 2'b00, 2'b00, 1'b0, 1);
      idex_wsel = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9;
      step("lu_rt",     5'b00111, 2'b01, 2'b00, 1'b0, 1);
      idle();

      // Store miss: four frozen cycles, then advance on dhit.
      do_reset();
      mem_dWEN = 1'b1;
      for (int i = 0; i < 4; i++)
         step("st_miss", 5'b00000, 2'b00, 2'b01, 1'b0, i);
      dhit = 1'b1;
      step("st_dhit",   5'b11111, 2'b00, 2'b01, 1'b0, 4);
      idle();
      step("st_run",    5'b11111, 2'b00, 2'b00, 1'b0, 4);

      // Redirect takes priority over load-use.
      ex_redirect = 1'b1; idex_dREN = 1'b1; idex_wsel = 5'd8; ifid_rt = 5'd8;
      step("redir_lu",  5'b11111, 2'b11, 2'b00, 1'b0, 4);
      idle();
      step("redir_aft", 5'b11111, 2'b00, 2'b00, 1'b0, 4);

      // Freeze beats redirect + load-use; hazards re-evaluated on dhit.
      ex_redirect = 1'b1; idex_dREN = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8; mem_dREN = 1'b1;
      step("frz_all",   5'b00000, 2'b00, 2'b10, 1'b0, 4);
      dhit = 1'b1;
      step("frz_dhit",  5'b11111, 2'b11, 2'b10, 1'b0, 5);
      idle();
      step("frz_run",   5'b11111, 2'b00, 2'b00, 1'b0, 5);

      // HALT leaves EX/MEM, then everything freezes.
      mem_halt = 1'b1;
      step("halt_adv",  5'b11111, 2'b00, 2'b00, 1'b0, 5);
      mem_halt = 1'b0; mem_dREN = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ihit = i[0]; dhit = ~i[0];
         step("halted",  5'b00000, 2'b00, 2'b00, 1'b1, 5);
      end

      // Saturation of the 4-bit stall counter.
      do_reset();
      ihit = 1'b0;
      for (int i = 0; i < 20; i++)
         step("sat", 5'b00000, 2'b00, 2'b00, 1'b0, (i > 15) ? 15 : i);
      step("sat_end", 5'b00000, 2'b00, 2'b00, 1'b0, 15);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
